// File: rtl/piece_pkg.sv
// rtl/piece_pkg.sv - shared types and defaults for the falling-piece controller
package piece_pkg;

   localparam int DEF_ROWS      = 12;
   localparam int DEF_COLS      = 10;
   localparam int DEF_SPAWN_ROW = 11;
   localparam int DEF_SPAWN_COL = 4;

   typedef enum logic [2:0] {
      ST_IDLE, ST_SPAWN, ST_CHECK, ST_WAIT, ST_EVAL, ST_LAND, ST_OVER
   } state_t;

   typedef enum logic [1:0] {OP_L, OP_R, OP_D, OP_T} op_t;

   typedef enum logic [1:0] {SH_O, SH_I, SH_T, SH_L} shape_t;

   // Selector codes above the defined shapes fall back to the O piece.
   function automatic shape_t sel_to_shape(input logic [2:0] sel);
      if (sel[2]) return SH_O;
      return shape_t'(sel[1:0]);
   endfunction

endpackage

// File: rtl/piece_cells.sv
// rtl/piece_cells.sv - anchor plus shape to four (row, col) cells, 4-bit wrapping
module piece_cells
   import piece_pkg::*;
(
   input  logic [3:0] i_row,
   input  logic [3:0] i_col,
   input  shape_t     i_shape,
   output logic [3:0] o_r1,
   output logic [3:0] o_c1,
   output logic [3:0] o_r2,
   output logic [3:0] o_c2,
   output logic [3:0] o_r3,
   output logic [3:0] o_c3,
   output logic [3:0] o_r4,
   output logic [3:0] o_c4
);

   logic [3:0] w_rm1, w_cm1, w_cp1, w_cp2;

   assign w_rm1 = i_row - 4'd1;
   assign w_cm1 = i_col - 4'd1;
   assign w_cp1 = i_col + 4'd1;
   assign w_cp2 = i_col + 4'd2;

   always_comb begin
      o_r1 = i_row; o_c1 = i_col;
      o_r2 = i_row; o_c2 = w_cp1;
      o_r3 = w_rm1; o_c3 = i_col;
      o_r4 = w_rm1; o_c4 = w_cp1;
      case (i_shape)
         SH_I: begin
            o_r1 = i_row; o_c1 = w_cm1;
            o_r2 = i_row; o_c2 = i_col;
            o_r3 = i_row; o_c3 = w_cp1;
            o_r4 = i_row; o_c4 = w_cp2;
         end
         SH_T: begin
            o_r1 = i_row; o_c1 = w_cm1;
            o_r2 = i_row; o_c2 = i_col;
            o_r3 = i_row; o_c3 = w_cp1;
            o_r4 = w_rm1; o_c4 = i_col;
         end
         SH_L: begin
            o_r1 = i_row; o_c1 = w_cm1;
            o_r2 = i_row; o_c2 = i_col;
            o_r3 = i_row; o_c3 = w_cp1;
            o_r4 = w_rm1; o_c4 = w_cm1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/piece_move_ctrl.sv
// rtl/piece_move_ctrl.sv - spawns, moves and lands the active piece against the board
module piece_move_ctrl
   import piece_pkg::*;
#(
   parameter int ROWS      = DEF_ROWS,
   parameter int COLS      = DEF_COLS,
   parameter int SPAWN_ROW = DEF_SPAWN_ROW,
   parameter int SPAWN_COL = DEF_SPAWN_COL
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 gen_flag,
   input  logic                 q_ini,
   input  logic [2:0]           piece_sel,
   input  logic                 btn_left,
   input  logic                 btn_right,
   input  logic                 btn_down,
   input  logic                 drop_tick,
   input  logic [ROWS*COLS-1:0] arr_flat,
   output logic [3:0]           x1,
   output logic [3:0]           y1,
   output logic [3:0]           x2,
   output logic [3:0]           y2,
   output logic [3:0]           x3,
   output logic [3:0]           y3,
   output logic [3:0]           x4,
   output logic [3:0]           y4,
   output logic                 bottom_flag,
   output logic                 top_flag,
   output logic                 active
);

   localparam int         IW      = $clog2(ROWS*COLS);
   localparam logic [3:0] ROWS_L  = 4'(ROWS);
   localparam logic [3:0] COLS_L  = 4'(COLS);
   localparam logic [3:0] SPAWN_R = 4'(SPAWN_ROW);
   localparam logic [3:0] SPAWN_C = 4'(SPAWN_COL);

   state_t     r_state;
   shape_t     r_shape;
   op_t        r_op;
   logic [3:0] r_row, r_col, r_cand_row, r_cand_col;
   logic [3:0] r_pend;
   logic       r_bottom, r_top, r_active;

   logic [3:0] w_cr1, w_cc1, w_cr2, w_cc2, w_cr3, w_cc3, w_cr4, w_cc4;
   logic [3:0] w_req, w_pick;
   op_t        w_pick_op;
   logic       w_cur_free, w_cand_free;

   // Out-of-board cells (including wrap to 15) never index the array.
   function automatic logic cell_blocked(input logic [3:0] r, input logic [3:0] c,
                                         input logic [ROWS*COLS-1:0] arr);
      logic [IW-1:0] idx;
      idx = IW'(r * COLS + c);
      if (r >= ROWS_L || c >= COLS_L) return 1'b1;
      return arr[idx];
   endfunction

   piece_cells u_cur (
      .i_row(r_row), .i_col(r_col), .i_shape(r_shape),
      .o_r1(x1), .o_c1(y1), .o_r2(x2), .o_c2(y2),
      .o_r3(x3), .o_c3(y3), .o_r4(x4), .o_c4(y4)
   );

   piece_cells u_cand (
      .i_row(r_cand_row), .i_col(r_cand_col), .i_shape(r_shape),
      .o_r1(w_cr1), .o_c1(w_cc1), .o_r2(w_cr2), .o_c2(w_cc2),
      .o_r3(w_cr3), .o_c3(w_cc3), .o_r4(w_cr4), .o_c4(w_cc4)
   );

   assign w_cur_free  = !(cell_blocked(x1, y1, arr_flat) || cell_blocked(x2, y2, arr_flat) ||
                          cell_blocked(x3, y3, arr_flat) || cell_blocked(x4, y4, arr_flat));
   assign w_cand_free = !(cell_blocked(w_cr1, w_cc1, arr_flat) || cell_blocked(w_cr2, w_cc2, arr_flat) ||
                          cell_blocked(w_cr3, w_cc3, arr_flat) || cell_blocked(w_cr4, w_cc4, arr_flat));

   assign w_req = {drop_tick, btn_down, btn_right, btn_left}
                  & {4{(r_state != ST_IDLE) && (r_state != ST_OVER)}};

   always_comb begin
      w_pick    = 4'b0000;
      w_pick_op = OP_L;
      if (r_pend[0])      begin w_pick = 4'b0001; w_pick_op = OP_L; end
      else if (r_pend[1]) begin w_pick = 4'b0010; w_pick_op = OP_R; end
      else if (r_pend[2]) begin w_pick = 4'b0100; w_pick_op = OP_D; end
      else if (r_pend[3]) begin w_pick = 4'b1000; w_pick_op = OP_T; end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state    <= ST_IDLE;
         r_shape    <= SH_O;
         r_op       <= OP_L;
         r_row      <= SPAWN_R;
         r_col      <= SPAWN_C;
         r_cand_row <= SPAWN_R;
         r_cand_col <= SPAWN_C;
         r_pend     <= 4'b0000;
         r_bottom   <= 1'b0;
         r_top      <= 1'b0;
         r_active   <= 1'b0;
      end else if (q_ini) begin
         r_state  <= ST_IDLE;
         r_pend   <= 4'b0000;
         r_bottom <= 1'b0;
         r_top    <= 1'b0;
         r_active <= 1'b0;
      end else begin
         r_bottom <= 1'b0;
         r_pend   <= r_pend | w_req;
         case (r_state)
            ST_IDLE: if (gen_flag) begin
               r_shape <= sel_to_shape(piece_sel);
               r_state <= ST_SPAWN;
            end
            ST_SPAWN: begin
               r_row   <= SPAWN_R;
               r_col   <= SPAWN_C;
               r_pend  <= 4'b0000;
               r_state <= ST_CHECK;
            end
            ST_CHECK: begin
               if (w_cur_free) begin
                  r_state  <= ST_WAIT;
                  r_active <= 1'b1;
               end else begin
                  r_state <= ST_OVER;
                  r_top   <= 1'b1;
               end
            end
            ST_WAIT: if (|r_pend) begin
               r_op       <= w_pick_op;
               r_cand_row <= (w_pick_op == OP_D || w_pick_op == OP_T) ? r_row - 4'd1 : r_row;
               r_cand_col <= (w_pick_op == OP_L) ? r_col - 4'd1 :
                             (w_pick_op == OP_R) ? r_col + 4'd1 : r_col;
               r_pend     <= (r_pend & ~w_pick) | w_req;
               r_state    <= ST_EVAL;
            end
            ST_EVAL: begin
               if (w_cand_free) begin
                  r_row   <= r_cand_row;
                  r_col   <= r_cand_col;
                  r_state <= ST_WAIT;
               end else if (r_op == OP_D || r_op == OP_T) begin
                  r_state  <= ST_LAND;
                  r_bottom <= 1'b1;
                  r_active <= 1'b0;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_LAND: r_state <= ST_IDLE;
            ST_OVER: r_state <= ST_OVER;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bottom_flag = r_bottom;
   assign top_flag    = r_top;
   assign active      = r_active;

endmodule

// File: tb/tb_piece_move_ctrl.sv
// tb/tb_piece_move_ctrl.sv - directed self-checking bench for piece_move_ctrl
module tb_piece_move_ctrl;

   logic         Clk = 1'b0;
   logic         Reset_n = 1'b1;
   logic         gen_flag = 1'b0, q_ini = 1'b0;
   logic [2:0]   piece_sel = 3'd0;
   logic         btn_left = 1'b0, btn_right = 1'b0, btn_down = 1'b0, drop_tick = 1'b0;
   logic [119:0] arr_flat = '0;
   logic [3:0]   x1, y1, x2, y2, x3, y3, x4, y4;
   logic         bottom_flag, top_flag, active;
   logic [31:0]  coords;
   logic [31:0]  left_exp [5];
   int           n_checks = 0;
   int           n_fail = 0;

   piece_move_ctrl dut (
      .Clk(Clk), .Reset_n(Reset_n), .gen_flag(gen_flag), .q_ini(q_ini),
      .piece_sel(piece_sel), .btn_left(btn_left), .btn_right(btn_right),
      .btn_down(btn_down), .drop_tick(drop_tick), .arr_flat(arr_flat),
      .x1(x1), .y1(y1), .x2(x2), .y2(y2), .x3(x3), .y3(y3), .x4(x4), .y4(y4),
      .bottom_flag(bottom_flag), .top_flag(top_flag), .active(active)
   );

   always #5 Clk = ~Clk;

   assign coords = {x1, y1, x2, y2, x3, y3, x4, y4};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic spawn(input logic [2:0] sel);
      piece_sel = sel; gen_flag = 1'b1; tick();
      gen_flag = 1'b0; tick(2);
   endtask

   task automatic drop();
      drop_tick = 1'b1; tick();
      drop_tick = 1'b0; tick(4);
   endtask

   task automatic abort();
      q_ini = 1'b1; tick();
      q_ini = 1'b0; tick();
   endtask

   initial begin
      left_exp[0] = 32'hB2B3B4B5;
      left_exp[1] = 32'hB1B2B3B4;
      left_exp[2] = 32'hB0B1B2B3;
      left_exp[3] = 32'hB0B1B2B3;
      left_exp[4] = 32'hB0B1B2B3;

      #3 Reset_n = 1'b0;
      #10;
      check("rst_coords", coords, 32'hB4B5A4A5);
      check("rst_bottom", {31'd0, bottom_flag}, 32'd0);
      check("rst_top", {31'd0, top_flag}, 32'd0);
      check("rst_active", {31'd0, active}, 32'd0);
      tick();
      Reset_n = 1'b1;
      tick();

      // O piece falls the full height of an empty board
      spawn(3'd0);
      check("spawn_o_coords", coords, 32'hB4B5A4A5);
      check("spawn_o_active", {31'd0, active}, 32'd1);
      check("spawn_o_top", {31'd0, top_flag}, 32'd0);
      for (int i = 0; i < 10; i++) drop();
      check("fall10_coords", coords, 32'h14150405);
      check("fall10_bottom", {31'd0, bottom_flag}, 32'd0);
      drop_tick = 1'b1; tick();
      drop_tick = 1'b0; tick(2);
      check("land_bottom", {31'd0, bottom_flag}, 32'd1);
      check("land_coords", coords, 32'h14150405);
      tick();
      check("land_bottom_pulse", {31'd0, bottom_flag}, 32'd0);
      check("land_idle_active", {31'd0, active}, 32'd0);
      check("land_idle_coords", coords, 32'h14150405);

      // I piece pushed into the left wall
      spawn(3'd1);
      check("spawn_i_coords", coords, 32'hB3B4B5B6);
      for (int i = 0; i < 5; i++) begin
         btn_left = 1'b1; tick();
         btn_left = 1'b0; tick(4);
         check($sformatf("left%0d_coords", i + 1), coords, left_exp[i]);
         check($sformatf("left%0d_bottom", i + 1), {31'd0, bottom_flag}, 32'd0);
      end
      abort();
      check("abort_i_active", {31'd0, active}, 32'd0);

      spawn(3'd2);
      check("spawn_t_coords", coords, 32'hB3B4B5A4);
      abort();
      spawn(3'd3);
      check("spawn_l_coords", coords, 32'hB3B4B5A3);
      btn_right = 1'b1; tick();
      btn_right = 1'b0; tick(4);
      check("right_l_coords", coords, 32'hB4B5B6A4);
      abort();
      spawn(3'd5);
      check("spawn_sel5_coords", coords, 32'hB4B5A4A5);
      abort();

      // Obstacle at row 5 column 5 stops the O piece at row 7
      arr_flat[55] = 1'b1;
      spawn(3'd0);
      for (int i = 0; i < 4; i++) drop();
      check("obst_coords", coords, 32'h74756465);
      drop_tick = 1'b1; tick();
      drop_tick = 1'b0; tick(2);
      check("obst_bottom", {31'd0, bottom_flag}, 32'd1);
      check("obst_land_coords", coords, 32'h74756465);
      tick();
      check("obst_idle_active", {31'd0, active}, 32'd0);
      arr_flat = '0;

      // Spawn collision holds top_flag until q_ini
      for (int i = 100; i < 110; i++) arr_flat[i] = 1'b1;
      spawn(3'd0);
      check("over_top", {31'd0, top_flag}, 32'd1);
      check("over_active", {31'd0, active}, 32'd0);
      btn_left = 1'b1; tick();
      btn_left = 1'b0; tick(5);
      check("over_top_held", {31'd0, top_flag}, 32'd1);
      check("over_coords", coords, 32'hB4B5A4A5);
      q_ini = 1'b1; tick();
      q_ini = 1'b0;
      check("over_clear_top", {31'd0, top_flag}, 32'd0);
      check("over_clear_active", {31'd0, active}, 32'd0);
      arr_flat = '0;
      tick();

      // Left and gravity together: left first, then down
      spawn(3'd0);
      check("respawn_active", {31'd0, active}, 32'd1);
      btn_left = 1'b1; drop_tick = 1'b1; tick();
      btn_left = 1'b0; drop_tick = 1'b0; tick(2);
      check("both_left_first", coords, 32'hB3B4A3A4);
      tick(2);
      check("both_then_down", coords, 32'hA3A49394);
      tick(6);
      check("both_latches_clear", coords, 32'hA3A49394);
      check("both_no_bottom", {31'd0, bottom_flag}, 32'd0);

      // gen_flag is ignored outside IDLE
      piece_sel = 3'd1; gen_flag = 1'b1; tick();
      gen_flag = 1'b0; tick(3);
      check("gen_ignored_coords", coords, 32'hA3A49394);
      check("gen_ignored_active", {31'd0, active}, 32'd1);

      // q_ini while the gravity candidate is in EVAL
      drop_tick = 1'b1; tick();
      drop_tick = 1'b0; tick();
      q_ini = 1'b1; btn_right = 1'b1; tick();
      q_ini = 1'b0; btn_right = 1'b0;
      check("qini_eval_active", {31'd0, active}, 32'd0);
      check("qini_eval_bottom", {31'd0, bottom_flag}, 32'd0);
      check("qini_eval_coords", coords, 32'hA3A49394);
      tick(4);
      check("qini_idle_bottom", {31'd0, bottom_flag}, 32'd0);
      check("qini_idle_coords", coords, 32'hA3A49394);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
